// File: rtl/rr_interval_ctrl_pkg.sv
// Shared encodings and default tuning for the R-R interval controller.
// Defaults are in samples; FSM encoding is visible on the debug state port.
package rr_interval_ctrl_pkg;

  localparam int DEF_CNT_W     = 16;
  localparam int DEF_REFRACT   = 50;
  localparam int DEF_MAX_RR    = 600;
  localparam int DEF_TACHY_LIM = 150;
  localparam int DEF_BRADY_LIM = 360;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARM   = 2'b01,
    ST_TRACK = 2'b10,
    ST_REFR  = 2'b11
  } state_t;

endpackage

// File: rtl/rr_interval_ctrl_avg8.sv
// rr_avg8: running mean of the last 8 intervals (circular buffer + running sum).
// Latency: avg/full update at the push edge; full rises with the 8th push.
// Backpressure: none, accepts a push every cycle; clr wipes history in one cycle.
module rr_avg8 #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [CNT_W-1:0] din,
  output logic [CNT_W-1:0] avg,
  output logic             full
);

  localparam int SUM_W = CNT_W + 3;

  logic [CNT_W-1:0] ring [8];
  logic [2:0]       wr_ptr;
  logic [3:0]       fill;
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] sum_n;

  // Unfilled slots hold zero, so subtracting the slot being overwritten is
  // correct both while filling and once the ring has wrapped.
  assign sum_n = sum + SUM_W'(din) - SUM_W'(ring[wr_ptr]);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < 8; i++) ring[i] <= '0;
      wr_ptr <= '0;
      fill   <= '0;
      sum    <= '0;
      avg    <= '0;
      full   <= 1'b0;
    end else if (push) begin
      ring[wr_ptr] <= din;
      wr_ptr       <= wr_ptr + 3'd1;
      sum          <= sum_n;
      if (fill != 4'd8) fill <= fill + 4'd1;
      if (fill >= 4'd7) begin
        avg  <= sum_n[SUM_W-1:3];
        full <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_interval_ctrl.sv
// R-R interval sequencer: refractory window, timeout, 8-beat average, beat records.
// Latency: record valid one clock after the accepting edge.
// Backpressure: record held until taken; a beat arriving on a blocked record is dropped and flagged.
module rr_interval_ctrl
  import rr_interval_ctrl_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int REFRACT   = DEF_REFRACT,
  parameter int MAX_RR    = DEF_MAX_RR,
  parameter int TACHY_LIM = DEF_TACHY_LIM,
  parameter int BRADY_LIM = DEF_BRADY_LIM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sample_tick,
  input  logic             r_peak,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] rr_out,
  output logic [CNT_W-1:0] rr_avg,
  output logic             avg_valid,
  output logic             tachy,
  output logic             brady,
  output logic             timeout,
  output logic             ovf_sticky,
  output logic [1:0]       state_o
);

  localparam logic [CNT_W-1:0] REFRACT_C = CNT_W'(REFRACT);
  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_RR);
  localparam logic [CNT_W-1:0] TACHY_C   = CNT_W'(TACHY_LIM);
  localparam logic [CNT_W-1:0] BRADY_C   = CNT_W'(BRADY_LIM);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] reload;
  logic             active;
  logic             hit;
  logic             accept;
  logic             avg_clr;

  always_comb begin
    active  = (state == ST_REFR) || (state == ST_TRACK);
    hit     = en && active && (cnt == MAX_C);
    accept  = en && (state == ST_TRACK) && r_peak && !hit;
    avg_clr = !en || hit;
    // The peak's own sample counts as sample 0 of the new interval.
    reload  = CNT_W'(sample_tick);
  end

  assign state_o = state;

  rr_avg8 #(.CNT_W(CNT_W)) u_avg (
    .clk  (clk),
    .rst  (rst),
    .clr  (avg_clr),
    .push (accept),
    .din  (cnt),
    .avg  (rr_avg),
    .full (avg_valid)
  );

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      rr_out    <= '0;
      tachy     <= 1'b0;
      brady     <= 1'b0;
      timeout   <= 1'b0;
      if (rst) ovf_sticky <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (accept) begin
        if (!out_valid || out_ready) begin
          out_valid <= 1'b1;
          rr_out    <= cnt;
          tachy     <= (cnt < TACHY_C);
          brady     <= (cnt > BRADY_C);
        end else begin
          ovf_sticky <= 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          state <= ST_ARM;
          cnt   <= '0;
        end
        ST_ARM: begin
          if (r_peak) begin
            state <= ST_REFR;
            cnt   <= reload;
          end
        end
        default: begin
          if (hit) begin
            // A peak landing on expiry re-arms straight into a fresh interval.
            timeout <= 1'b1;
            if (r_peak) begin
              state <= ST_REFR;
              cnt   <= reload;
            end else begin
              state <= ST_ARM;
              cnt   <= '0;
            end
          end else if (accept) begin
            state <= ST_REFR;
            cnt   <= reload;
          end else begin
            if (sample_tick && cnt != MAX_C) cnt <= cnt + 1'b1;
            if (state == ST_REFR && cnt >= REFRACT_C) state <= ST_TRACK;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_interval_ctrl.sv
// Directed bench for rr_interval_ctrl: rhythm, refractory, averaging, timeout, backpressure, reset/enable.
module tb_rr_interval_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        sample_tick = 1'b0;
  logic        r_peak = 1'b0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [15:0] rr_out;
  logic [15:0] rr_avg;
  logic        avg_valid;
  logic        tachy;
  logic        brady;
  logic        timeout;
  logic        ovf_sticky;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_interval_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .sample_tick (sample_tick),
    .r_peak      (r_peak),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .rr_out      (rr_out),
    .rr_avg      (rr_avg),
    .avg_valid   (avg_valid),
    .tachy       (tachy),
    .brady       (brady),
    .timeout     (timeout),
    .ovf_sticky  (ovf_sticky),
    .state_o     (state_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic tk, input logic pk);
    sample_tick = tk;
    r_peak      = pk;
    @(posedge clk);
    #1;
    r_peak = 1'b0;
  endtask

  task automatic samples(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  // Peak lands n samples after the previous peak's sample.
  task automatic beat_after(input int n);
    samples(n - 1);
    step(1'b1, 1'b1);
  endtask

  task automatic check_cleared(input string tag, input logic [31:0] ovf_exp);
    check({tag, "_vld"},   32'(out_valid),  0);
    check({tag, "_rr"},    32'(rr_out),     0);
    check({tag, "_avg"},   32'(rr_avg),     0);
    check({tag, "_avgv"},  32'(avg_valid),  0);
    check({tag, "_tachy"}, 32'(tachy),      0);
    check({tag, "_brady"}, 32'(brady),      0);
    check({tag, "_tmo"},   32'(timeout),    0);
    check({tag, "_ovf"},   32'(ovf_sticky), ovf_exp);
    check({tag, "_state"}, 32'(state_o),    0);
  endtask

  initial begin
    // Reset state
    rst = 1'b1; en = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_cleared("rst", 0);

    // 1: steady rhythm at 200 samples
    rst = 1'b0;
    step(1'b1, 1'b0);
    check("arm_state", 32'(state_o), 1);
    step(1'b1, 1'b1);
    check("first_peak_state", 32'(state_o), 3);
    check("first_peak_noreport", 32'(out_valid), 0);
    beat_after(200);
    check("t1_b1_vld", 32'(out_valid), 1);
    check("t1_b1_rr", 32'(rr_out), 200);
    check("t1_b1_tachy", 32'(tachy), 0);
    check("t1_b1_brady", 32'(brady), 0);
    check("t1_b1_state", 32'(state_o), 3);
    step(1'b1, 1'b0);
    check("t1_b1_taken", 32'(out_valid), 0);
    beat_after(199);
    check("t1_b2_vld", 32'(out_valid), 1);
    check("t1_b2_rr", 32'(rr_out), 200);

    // 2: peak inside refractory is ignored
    samples(19);
    step(1'b1, 1'b1);
    check("t2_ignored_vld", 32'(out_valid), 0);
    check("t2_ignored_state", 32'(state_o), 3);
    beat_after(180);
    check("t2_vld", 32'(out_valid), 1);
    check("t2_rr", 32'(rr_out), 200);

    // 3: eight beats at 100, then 180 and 400
    rst = 1'b1;
    step(1'b1, 1'b0);
    rst = 1'b0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      beat_after(100);
      check("t3_vld", 32'(out_valid), 1);
      check("t3_rr", 32'(rr_out), 100);
      check("t3_tachy", 32'(tachy), 1);
      check("t3_avgv", 32'(avg_valid), (i == 7) ? 1 : 0);
      check("t3_avg", 32'(rr_avg), (i == 7) ? 100 : 0);
    end
    beat_after(180);
    check("t3_b9_rr", 32'(rr_out), 180);
    check("t3_b9_tachy", 32'(tachy), 0);
    check("t3_b9_avg", 32'(rr_avg), 110);
    beat_after(400);
    check("t3_b10_rr", 32'(rr_out), 400);
    check("t3_b10_brady", 32'(brady), 1);
    check("t3_b10_tachy", 32'(tachy), 0);
    check("t3_b10_avg", 32'(rr_avg), 147);

    // 4: lost rhythm
    samples(599);
    check("t4_pre_tmo", 32'(timeout), 0);
    check("t4_pre_state", 32'(state_o), 2);
    step(1'b1, 1'b0);
    check("t4_tmo", 32'(timeout), 1);
    check("t4_avgv", 32'(avg_valid), 0);
    check("t4_avg", 32'(rr_avg), 0);
    check("t4_state", 32'(state_o), 1);
    step(1'b1, 1'b0);
    check("t4_tmo_pulse", 32'(timeout), 0);
    step(1'b1, 1'b1);
    check("t4_peak_noreport", 32'(out_valid), 0);
    check("t4_peak_state", 32'(state_o), 3);

    // 5: backpressure drops the second beat
    out_ready = 1'b0;
    beat_after(100);
    check("t5_b1_vld", 32'(out_valid), 1);
    check("t5_b1_rr", 32'(rr_out), 100);
    check("t5_b1_ovf", 32'(ovf_sticky), 0);
    beat_after(120);
    check("t5_b2_vld", 32'(out_valid), 1);
    check("t5_b2_held_rr", 32'(rr_out), 100);
    check("t5_b2_ovf", 32'(ovf_sticky), 1);
    samples(3);
    check("t5_stable_rr", 32'(rr_out), 100);
    out_ready = 1'b1;
    step(1'b1, 1'b0);
    check("t5_taken_vld", 32'(out_valid), 0);
    check("t5_ovf_kept", 32'(ovf_sticky), 1);

    // 5b: take-and-reload in the same cycle
    out_ready = 1'b0;
    beat_after(86);
    check("t5b_first_rr", 32'(rr_out), 90);
    samples(129);
    out_ready = 1'b1;
    step(1'b1, 1'b1);
    check("t5b_reload_vld", 32'(out_valid), 1);
    check("t5b_reload_rr", 32'(rr_out), 130);

    // 6: reset mid-track with a pending record, then enable drop
    out_ready = 1'b0;
    beat_after(100);
    check("t6_pend_vld", 32'(out_valid), 1);
    rst = 1'b1;
    step(1'b1, 1'b0);
    check_cleared("t6_rst", 0);
    rst = 1'b0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    beat_after(100);
    beat_after(100);
    check("t6_ovf_set", 32'(ovf_sticky), 1);
    check("t6_track_state", 32'(state_o), 3);
    en = 1'b0;
    step(1'b1, 1'b0);
    check_cleared("t6_en", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
